// File: rtl/mux_nto1_rr_pkg.sv
// Shared definitions for the N:1 valid/ready multiplexer.
//   MODE_SEL   - channel chosen by the select input
//   MODE_RR    - channel chosen by the internal round-robin arbiter
//   clog2_min1 - index width for N channels, never less than one bit
package mux_nto1_rr_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Smallest width that can index `value` entries, clamped to at least 1.
    function automatic int clog2_min1(input int value);
        int width_v;
        width_v = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width_v = i + 1;
            end else begin
                width_v = width_v;
            end
        end
        return width_v;
    endfunction

endpackage

// File: rtl/mux_nto1_rr_rr_arbiter.sv
// Round-robin arbiter for the N:1 multiplexer.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset (clears the pointer)
//   req_i         - per-channel request vector
//   adv_i         - a transfer happens this cycle on the granted channel
//   grant_idx_o   - index of the granted channel (combinational)
//   grant_vld_o   - some channel is granted (combinational)
module mux_nto1_rr_rr_arbiter
    import mux_nto1_rr_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             adv_i,
    output logic [SEL_W-1:0] grant_idx_o,
    output logic             grant_vld_o
);

    localparam logic [SEL_W-1:0] IDX_ZERO = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(32'd1);

    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] grant_idx_s;
    logic             grant_vld_s;
    int               idx_v;

    // Pick the first requester at or after the pointer, wrapping once.
    always_comb begin
        grant_idx_s = IDX_ZERO;
        grant_vld_s = 1'b0;
        idx_v       = 0;
        for (int i = 0; i < N; i++) begin
            idx_v = (int'(ptr_r) + i) % N;
            if (!grant_vld_s && req_i[idx_v]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = SEL_W'(idx_v);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // After a transfer the channel just served becomes lowest priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r <= IDX_ZERO;
        end else if (adv_i) begin
            ptr_r <= (int'(grant_idx_s) == N - 1) ? IDX_ZERO : grant_idx_s + IDX_ONE;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant_idx_o = grant_idx_s;
    assign grant_vld_o = grant_vld_s;

endmodule

// File: rtl/mux_nto1_rr.sv
// N-input, WIDTH-bit multiplexer with valid/ready handshake and a one-entry
// registered output stage. The channel is steered by select_i (MODE_SEL) or
// chosen by a round-robin arbiter (MODE_RR).
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   data_i       - channel k at bits [k*WIDTH +: WIDTH]
//   valid_i      - channel k offers data
//   ready_o      - channel k accepted this cycle (combinational, one-hot or zero)
//   select_i     - requested channel, MODE_SEL only
//   data_o       - registered output beat
//   valid_o      - output register holds a beat
//   ready_i      - downstream takes the beat
//   src_o        - channel index of the beat on data_o
module mux_nto1_rr
    import mux_nto1_rr_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  N     = 4,
    parameter int  MODE  = MODE_SEL,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N*WIDTH-1:0] data_i,
    input  logic [N-1:0]       valid_i,
    output logic [N-1:0]       ready_o,
    input  logic [SEL_W-1:0]   select_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [SEL_W-1:0]   src_o
);

    logic [SEL_W-1:0] grant_idx_s;
    logic             granted_s;
    logic             load_en_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [WIDTH-1:0] data_r;
    logic [SEL_W-1:0] src_r;
    logic             valid_r;

    if (MODE == MODE_RR) begin : g_rr
        logic unused_select_s;
        assign unused_select_s = ^select_i;

        mux_nto1_rr_rr_arbiter #(
            .N     (N),
            .SEL_W (SEL_W)
        ) u_arb (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .req_i       (valid_i),
            .adv_i       (xfer_s),
            .grant_idx_o (grant_idx_s),
            .grant_vld_o (granted_s)
        );
    end else begin : g_sel
        // Steered grant; an out-of-range select matches no channel.
        always_comb begin
            grant_idx_s = select_i;
            granted_s   = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (int'(select_i) == k) begin
                    granted_s = valid_i[k];
                end else begin
                    granted_s = granted_s;
                end
            end
        end
    end

    // A draining full register may reload in the same cycle.
    assign load_en_s = !valid_r || ready_i;
    assign xfer_s    = load_en_s && granted_s && !rst_i;

    // One-hot accept strobe towards the granted producer.
    always_comb begin
        ready_o = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (xfer_s && (int'(grant_idx_s) == k)) begin
                ready_o[k] = 1'b1;
            end else begin
                ready_o[k] = 1'b0;
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (int'(grant_idx_s) == k) begin
                sel_data_s = data_i[k*WIDTH +: WIDTH];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Output register: load on transfer, empty when drained, hold otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            src_r   <= {SEL_W{1'b0}};
        end else if (xfer_s) begin
            valid_r <= 1'b1;
            data_r  <= sel_data_s;
            src_r   <= grant_idx_s;
        end else if (ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign data_o  = data_r;
    assign valid_o = valid_r;
    assign src_o   = src_r;

endmodule

// File: doc/mux_nto1_rr.md
# mux_nto1_rr

Parametrised N-input, WIDTH-bit multiplexer with valid/ready flow control and a one-entry registered output stage. It succeeds the fixed 2:1 datapath mux wherever the selected source is a producer that may stall: write-back source selection, memory-port sharing, multi-master buses. Channel choice is either steered by `select_i` or by an internal round-robin arbiter, fixed at elaboration by `MODE`.

## Interface
- `WIDTH`, 32, data width per channel
- `N`, 4, number of input channels, ≥2
- `MODE`, 0, 0 = select-steered (MODE_SEL), 1 = round-robin arbitration (MODE_RR)
- `SEL_W`, localparam = max(1, clog2(N)), channel index width
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `data_i`  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- `valid_i`  in  N  channel k offers data
- `ready_o`  out  N  channel k data accepted this cycle
- `select_i`  in  SEL_W  requested channel; used only when MODE=0
- `data_o`  out  WIDTH  registered output data
- `valid_o`  out  1  output register holds a beat
- `ready_i`  in  1  downstream accepts beat
- `src_o`  out  SEL_W  channel index of the beat on `data_o`

## Operation
- Output register has two states: EMPTY (`valid_o`=0), FULL (`valid_o`=1).
- `load_en = !valid_o || ready_i` (a FULL register that is draining this cycle can reload; full throughput).
- Grant: MODE=0: `g = select_i`, granted if `select_i < N` and `valid_i[g]`. MODE=1: first k with `valid_i[k]=1`, searching k = ptr, ptr+1, … mod N.
- `ready_o[k] = load_en && granted && (k == g)`; at most one bit set. All zero when nothing is granted or `rst_i`=1.
- Transfer on channel g: next cycle `data_o = data_i[g]`, `src_o = g`, `valid_o = 1`.
- No transfer and `ready_i`=1: `valid_o` → 0; `data_o`/`src_o` hold last value.
- `valid_o`=1 and `ready_i`=0: `data_o`, `src_o`, `valid_o` held stable; no `ready_o` asserted.
- Round-robin pointer: after a transfer on g, `ptr = (g+1) mod N` (wrap N-1 → 0). Unchanged when no transfer. Not used in MODE=0.
- `select_i` ≥ N (N not a power of two): no grant, no state change.
- Reset values: `valid_o`=0, `data_o`=0, `src_o`=0, `ptr`=0. Reset mid-transfer drops the held beat; `rst_i` dominates any same-cycle handshake.

## Timing
- Latency: input accepted in cycle t appears on `data_o` with `valid_o`=1 in cycle t+1.
- Throughput: one beat per cycle when `ready_i` held high.
- `ready_o` is combinational from `valid_i`, `select_i`, `ready_i`, `valid_o`, `ptr`; `data_o`, `valid_o`, `src_o` are register outputs only.
- Producers must hold `valid_i`/`data_i` until `ready_o`; block never depends on `ready_o` → `valid_i` loops.

## Structure
- Shared header/package: `MODE_SEL`=0, `MODE_RR`=1, clog2 helper.
- Sub-module `rr_arbiter` (N, SEL_W): request vector, `ptr`, advance strobe → grant index, grant-valid; owns the pointer register and its reset. Instantiated only under MODE=1 (generate).
- Top holds grant muxing, `ready_o` decode, output register.

## Test plan
- Reset: assert `rst_i` 2 cycles with all `valid_i`=1 → `valid_o`=0, `data_o`=0, `src_o`=0, `ready_o`=0000 throughout.
- MODE=0, N=4: `select_i`=2, `valid_i`=0100, `data_i[2]`=0xDEADBEEF, `ready_i`=1 → `ready_o`=0100 cycle t, `data_o`=0xDEADBEEF, `src_o`=2, `valid_o`=1 cycle t+1.
- MODE=0 mismatch: `select_i`=1, `valid_i`=0100 → `ready_o`=0000, `valid_o` falls to 0.
- MODE=1, all four valid, `ready_i`=1, data k = 0x10+k → `src_o` sequence 0,1,2,3,0 on consecutive cycles, `data_o` 0x10,0x11,0x12,0x13,0x10.
- Backpressure: FULL with 0xA5, `ready_i`=0 for 3 cycles while `valid_i`=1111 → `data_o`=0xA5, `src_o` stable, `ready_o`=0000; on `ready_i`=1 next grant is ptr channel, single-cycle reload, no gap.
- N=3, MODE=0, `select_i`=3 → no grant, no change; MODE=1 grant after channel 2 wraps to 0.
